// File: rtl/rv32i_if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous
// instruction memory with a fixed one-cycle read latency (slave).
interface rv32i_if_fetch_if;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/rv32i_if_fetch.sv
// RV32I instruction-fetch stage: owns the PC, reads a 1-cycle-latency imem,
// buffers one word in a skid register and applies jump redirects from decode.
module rv32i_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IW   = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_in,
    input  logic                    halt_in,
    input  logic                    jump_en_in,
    input  logic [31:0]             jump_addr_in,
    rv32i_if_fetch_if.master        imem,
    output logic [31:0]             pc_out,
    output logic [31:0]             iw_out,
    output logic                    iw_valid,
    output logic                    jump_en_out,
    output logic                    misalign_err
);

    // Handshake: iw_valid qualifies {pc_out, iw_out}. Decode takes the word in
    // any cycle where stall_in is low; while stall_in is high the word is held.

    logic [31:0] pc_q;
    logic        req_pending;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_iw;

    logic        issue;
    logic [31:0] issue_addr;

    logic [31:0] pc_q_d;
    logic        req_pending_d;
    logic [31:0] req_pc_d;
    logic        skid_valid_d;
    logic [31:0] skid_pc_d;
    logic [31:0] skid_iw_d;
    logic [31:0] pc_out_d;
    logic [31:0] iw_out_d;
    logic        iw_valid_d;
    logic        jump_en_out_d;
    logic        misalign_err_d;

    // A full skid always coincides with stall_in, so the stall term alone blocks
    // issue; the cycle stall drops the skid drains and a new fetch goes out.
    always_comb begin
        issue      = 1'b0;
        issue_addr = pc_q;
        if (reset) begin
            issue = 1'b0;
        end else if (jump_en_in) begin
            issue      = 1'b1;
            issue_addr = {jump_addr_in[31:2], 2'b00};
        end else if (!halt_in && !stall_in) begin
            issue      = 1'b1;
            issue_addr = pc_q;
        end
    end

    assign imem.imem_rd_en = issue;
    assign imem.imem_addr  = issue_addr;

    always_comb begin
        pc_q_d         = issue ? issue_addr + 32'd4 : pc_q;
        req_pending_d  = issue;
        req_pc_d       = issue ? issue_addr : req_pc;
        skid_valid_d   = skid_valid;
        skid_pc_d      = skid_pc;
        skid_iw_d      = skid_iw;
        pc_out_d       = pc_out;
        iw_out_d       = iw_out;
        iw_valid_d     = iw_valid;
        jump_en_out_d  = jump_en_in;
        misalign_err_d = misalign_err | (jump_en_in & (|jump_addr_in[1:0]));

        if (jump_en_in) begin
            // Redirect squashes both the in-flight response and any buffered word.
            skid_valid_d = 1'b0;
            iw_out_d     = NOP_IW;
            iw_valid_d   = 1'b0;
        end else if (stall_in) begin
            if (req_pending) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = req_pc;
                skid_iw_d    = imem.imem_rdata;
            end
        end else if (skid_valid) begin
            pc_out_d     = skid_pc;
            iw_out_d     = skid_iw;
            iw_valid_d   = 1'b1;
            skid_valid_d = 1'b0;
        end else if (req_pending) begin
            pc_out_d   = req_pc;
            iw_out_d   = imem.imem_rdata;
            iw_valid_d = 1'b1;
        end else begin
            iw_out_d   = NOP_IW;
            iw_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            req_pending  <= 1'b0;
            req_pc       <= 32'h0;
            skid_valid   <= 1'b0;
            skid_pc      <= 32'h0;
            skid_iw      <= NOP_IW;
            pc_out       <= 32'h0;
            iw_out       <= NOP_IW;
            iw_valid     <= 1'b0;
            jump_en_out  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc_q         <= pc_q_d;
            req_pending  <= req_pending_d;
            req_pc       <= req_pc_d;
            skid_valid   <= skid_valid_d;
            skid_pc      <= skid_pc_d;
            skid_iw      <= skid_iw_d;
            pc_out       <= pc_out_d;
            iw_out       <= iw_out_d;
            iw_valid     <= iw_valid_d;
            jump_en_out  <= jump_en_out_d;
            misalign_err <= misalign_err_d;
        end
    end

endmodule

// File: tb/tb_rv32i_if_fetch.sv
// Bench for rv32i_if_fetch: directed scenarios plus a randomized run checked
// against a fetched-but-undelivered queue model of the fetch stream.
module tb_rv32i_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IW   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic        halt_in = 1'b0;
    logic        jump_en_in = 1'b0;
    logic [31:0] jump_addr_in = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] iw_out;
    logic        iw_valid;
    logic        jump_en_out;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_if_fetch_if imem ();

    rv32i_if_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_IW   (NOP_IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_in     (stall_in),
        .halt_in      (halt_in),
        .jump_en_in   (jump_en_in),
        .jump_addr_in (jump_addr_in),
        .imem         (imem.master),
        .pc_out       (pc_out),
        .iw_out       (iw_out),
        .iw_valid     (iw_valid),
        .jump_en_out  (jump_en_out),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h0000_00A0;
    endfunction

    // Synchronous memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        imem.imem_rdata <= imem.imem_rd_en ? mem_word(imem.imem_addr) : $urandom();
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; stall_in = 1'b0; halt_in = 1'b0; jump_en_in = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if ({pc_out, iw_out, iw_valid, jump_en_out, misalign_err, imem.imem_rd_en} !== {32'h0, NOP_IW, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h iw=%h v=%b je=%b mis=%b rd=%b, exp pc=0 iw=%h v=0 je=0 mis=0 rd=0",
                     pc_out, iw_out, iw_valid, jump_en_out, misalign_err, imem.imem_rd_en, NOP_IW);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL first_issue: got rd=%b addr=%h, exp rd=1 addr=%h", imem.imem_rd_en, imem.imem_addr, RESET_PC);
        end
        tick();
        n_checks++;
        if (iw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_latency: got iw_valid=%b, exp 0", iw_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            a = 32'(i * 4);
            n_checks++;
            if ({pc_out, iw_out, iw_valid} !== {a, mem_word(a), 1'b1}) begin
                n_fail++;
                $display("FAIL seq_word: got pc=%h iw=%h v=%b, exp pc=%h iw=%h v=1", pc_out, iw_out, iw_valid, a, mem_word(a));
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] a;
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (imem.imem_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_no_issue: got rd=%b, exp 0", imem.imem_rd_en);
            end
            tick();
            n_checks++;
            if ({pc_out, iw_out, iw_valid} !== {32'h8, mem_word(32'h8), 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold: got pc=%h iw=%h v=%b, exp pc=8 iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'h8));
            end
        end
        stall_in = 1'b0;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL drain_issue: got rd=%b addr=%h, exp rd=1 addr=10", imem.imem_rd_en, imem.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            a = 32'(12 + i * 4);
            n_checks++;
            if ({pc_out, iw_out, iw_valid} !== {a, mem_word(a), 1'b1}) begin
                n_fail++;
                $display("FAIL stall_release: got pc=%h iw=%h v=%b, exp pc=%h iw=%h v=1", pc_out, iw_out, iw_valid, a, mem_word(a));
            end
        end
    endtask

    task automatic test_jump;
        jump_en_in = 1'b1; jump_addr_in = 32'h100;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL jump_issue: got rd=%b addr=%h, exp rd=1 addr=100", imem.imem_rd_en, imem.imem_addr);
        end
        tick();
        jump_en_in = 1'b0;
        n_checks++;
        if ({iw_out, iw_valid, jump_en_out} !== {NOP_IW, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL jump_squash: got iw=%h v=%b je=%b, exp iw=%h v=0 je=1", iw_out, iw_valid, jump_en_out, NOP_IW);
        end
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h104}) begin
            n_fail++;
            $display("FAIL jump_seq_issue: got rd=%b addr=%h, exp rd=1 addr=104", imem.imem_rd_en, imem.imem_addr);
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid, jump_en_out} !== {32'h100, mem_word(32'h100), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_target: got pc=%h iw=%h v=%b je=%b, exp pc=100 iw=%h v=1 je=0", pc_out, iw_out, iw_valid, jump_en_out, mem_word(32'h100));
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {32'h104, mem_word(32'h104), 1'b1}) begin
            n_fail++;
            $display("FAIL jump_next: got pc=%h iw=%h v=%b, exp pc=104 iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'h104));
        end
    endtask

    task automatic test_jump_stall_skid;
        stall_in = 1'b1;
        tick();
        n_checks++;
        if ({pc_out, iw_valid} !== {32'h104, 1'b1}) begin
            n_fail++;
            $display("FAIL skid_fill_hold: got pc=%h v=%b, exp pc=104 v=1", pc_out, iw_valid);
        end
        jump_en_in = 1'b1; jump_addr_in = 32'h200;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL jump_stall_issue: got rd=%b addr=%h, exp rd=1 addr=200", imem.imem_rd_en, imem.imem_addr);
        end
        tick();
        jump_en_in = 1'b0; stall_in = 1'b0;
        n_checks++;
        if ({iw_out, iw_valid, jump_en_out} !== {NOP_IW, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL jump_stall_squash: got iw=%h v=%b je=%b, exp iw=%h v=0 je=1", iw_out, iw_valid, jump_en_out, NOP_IW);
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {32'h200, mem_word(32'h200), 1'b1}) begin
            n_fail++;
            $display("FAIL skid_discard: got pc=%h iw=%h v=%b, exp pc=200 iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'h200));
        end
    endtask

    task automatic test_misalign_wrap;
        jump_en_in = 1'b1; jump_addr_in = 32'h102;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL misalign_issue: got rd=%b addr=%h, exp rd=1 addr=100", imem.imem_rd_en, imem.imem_addr);
        end
        tick();
        jump_en_in = 1'b0;
        n_checks++;
        if ({misalign_err, jump_en_out, iw_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL misalign_set: got mis=%b je=%b v=%b, exp mis=1 je=1 v=0", misalign_err, jump_en_out, iw_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({pc_out, iw_valid, misalign_err} !== {32'(32'h100 + i * 4), 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL misalign_sticky: got pc=%h v=%b mis=%b, exp pc=%h v=1 mis=1", pc_out, iw_valid, misalign_err, 32'(32'h100 + i * 4));
            end
        end
        jump_en_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
        tick();
        jump_en_in = 1'b0;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_addr: got rd=%b addr=%h, exp rd=1 addr=0", imem.imem_rd_en, imem.imem_addr);
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_top: got pc=%h iw=%h v=%b, exp pc=fffffffc iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'hFFFF_FFFC));
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {32'h0, mem_word(32'h0), 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_zero: got pc=%h iw=%h v=%b, exp pc=0 iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'h0));
        end
    endtask

    task automatic test_halt;
        jump_en_in = 1'b1; jump_addr_in = 32'h300;
        tick();
        jump_en_in = 1'b0;
        tick();
        n_checks++;
        if ({pc_out, iw_valid} !== {32'h300, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_setup: got pc=%h v=%b, exp pc=300 v=1", pc_out, iw_valid);
        end
        halt_in = 1'b1;
        #1;
        n_checks++;
        if (imem.imem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_no_issue: got rd=%b, exp 0", imem.imem_rd_en);
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {32'h304, mem_word(32'h304), 1'b1}) begin
            n_fail++;
            $display("FAIL halt_inflight: got pc=%h iw=%h v=%b, exp pc=304 iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'h304));
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({pc_out, iw_out, iw_valid} !== {32'h304, NOP_IW, 1'b0}) begin
                n_fail++;
                $display("FAIL halt_nop: got pc=%h iw=%h v=%b, exp pc=304 iw=%h v=0", pc_out, iw_out, iw_valid, NOP_IW);
            end
        end
        halt_in = 1'b0;
        #1;
        n_checks++;
        if ({imem.imem_rd_en, imem.imem_addr} !== {1'b1, 32'h308}) begin
            n_fail++;
            $display("FAIL halt_resume: got rd=%b addr=%h, exp rd=1 addr=308", imem.imem_rd_en, imem.imem_addr);
        end
        tick();
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {32'h308, mem_word(32'h308), 1'b1}) begin
            n_fail++;
            $display("FAIL halt_resume_word: got pc=%h iw=%h v=%b, exp pc=308 iw=%h v=1", pc_out, iw_out, iw_valid, mem_word(32'h308));
        end
    endtask

    task automatic test_reset_mid;
        jump_en_in = 1'b1; jump_addr_in = 32'h400;
        tick();
        jump_en_in = 1'b0; reset = 1'b1;
        #1;
        n_checks++;
        if (imem.imem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_issue: got rd=%b, exp 0", imem.imem_rd_en);
        end
        tick();
        reset = 1'b0;
        n_checks++;
        if ({pc_out, iw_out, iw_valid, jump_en_out, misalign_err} !== {32'h0, NOP_IW, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid_state: got pc=%h iw=%h v=%b je=%b mis=%b, exp pc=0 iw=%h v=0 je=0 mis=0",
                     pc_out, iw_out, iw_valid, jump_en_out, misalign_err, NOP_IW);
        end
        tick();
        n_checks++;
        if ({iw_out, iw_valid} !== {NOP_IW, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_stale: got iw=%h v=%b, exp iw=%h v=0", iw_out, iw_valid, NOP_IW);
        end
        tick();
        n_checks++;
        if ({pc_out, iw_out, iw_valid} !== {RESET_PC, mem_word(RESET_PC), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_restart: got pc=%h iw=%h v=%b, exp pc=%h iw=%h v=1", pc_out, iw_out, iw_valid, RESET_PC, mem_word(RESET_PC));
        end
    endtask

    // Model: exp_q holds fetch addresses issued but not yet shown to decode.
    task automatic test_random;
        logic [31:0] exp_q[$];
        logic [31:0] exp_fetch, exp_addr, shown_pc, shown_iw, tgt, r_addr;
        logic        shown_valid, exp_mis, exp_issue;
        logic        r_reset, r_stall, r_halt, r_jump;
        int          owed;
        reset = 1'b1; stall_in = 1'b0; halt_in = 1'b0; jump_en_in = 1'b0;
        tick();
        exp_q.delete();
        exp_fetch = RESET_PC; shown_pc = 32'h0; shown_iw = NOP_IW; shown_valid = 1'b0; exp_mis = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_reset = ($urandom_range(0, 99) < 2);
            r_stall = ($urandom_range(0, 99) < 25);
            r_halt  = ($urandom_range(0, 99) < 10);
            r_jump  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       r_addr = 32'hFFFF_FFFC;
                1:       r_addr = $urandom();
                default: r_addr = $urandom() & 32'h0000_FFFC;
            endcase
            reset = r_reset; stall_in = r_stall; halt_in = r_halt;
            jump_en_in = r_jump; jump_addr_in = r_addr;
            exp_issue = !r_reset && (r_jump || (!r_halt && !r_stall));
            tgt = {r_addr[31:2], 2'b00};
            exp_addr = r_jump ? tgt : exp_fetch;
            #1;
            n_checks++;
            if (imem.imem_rd_en !== exp_issue) begin
                n_fail++;
                $display("FAIL rand_rd_en: cycle %0d got %b exp %b", c, imem.imem_rd_en, exp_issue);
            end
            if (exp_issue) begin
                n_checks++;
                if (imem.imem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL rand_addr: cycle %0d got %h exp %h", c, imem.imem_addr, exp_addr);
                end
            end
            owed = exp_q.size();
            tick();
            if (r_reset) begin
                exp_q.delete();
                exp_fetch = RESET_PC; shown_pc = 32'h0; shown_iw = NOP_IW; shown_valid = 1'b0; exp_mis = 1'b0;
                n_checks++;
                if ({pc_out, iw_out, iw_valid, jump_en_out, misalign_err} !== {32'h0, NOP_IW, 3'b000}) begin
                    n_fail++;
                    $display("FAIL rand_reset: cycle %0d got pc=%h iw=%h v=%b je=%b mis=%b", c, pc_out, iw_out, iw_valid, jump_en_out, misalign_err);
                end
            end else begin
                if (r_jump) begin
                    if (r_addr[1:0] != 2'b00) exp_mis = 1'b1;
                    exp_q.delete();
                    shown_iw = NOP_IW; shown_valid = 1'b0;
                end else if (!r_stall) begin
                    if (owed > 0) begin
                        shown_pc = exp_q.pop_front();
                        shown_iw = mem_word(shown_pc);
                        shown_valid = 1'b1;
                    end else begin
                        shown_iw = NOP_IW; shown_valid = 1'b0;
                    end
                end
                if (exp_issue) begin
                    exp_q.push_back(exp_addr);
                    exp_fetch = exp_addr + 32'd4;
                end
                n_checks++;
                if ({pc_out, iw_out, iw_valid} !== {shown_pc, shown_iw, shown_valid}) begin
                    n_fail++;
                    $display("FAIL rand_out: cycle %0d got pc=%h iw=%h v=%b exp pc=%h iw=%h v=%b",
                             c, pc_out, iw_out, iw_valid, shown_pc, shown_iw, shown_valid);
                end
                n_checks++;
                if ({jump_en_out, misalign_err} !== {r_jump, exp_mis}) begin
                    n_fail++;
                    $display("FAIL rand_flags: cycle %0d got je=%b mis=%b exp je=%b mis=%b", c, jump_en_out, misalign_err, r_jump, exp_mis);
                end
            end
        end
        reset = 1'b0; stall_in = 1'b0; halt_in = 1'b0; jump_en_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_jump_stall_skid();
        test_misalign_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, exp finish");
        $fatal(1, "watchdog");
    end

endmodule
